out_line_sequencer: RTL

- Read-side stage directly downstream of the line-interpolation datapath, running on the read clock `aclk`.
- Drains the two asynchronous line FIFOs in alternation:
  - even output rows come from the pass-through line FIFO (`afifo1`);
  - odd output rows come from the column-interpolated line FIFO (`afifo0`).
- Emits one upscaled frame as a valid/ready pixel stream with start-of-frame and end-of-line tags.
- Issues FIFO reads against a credit count so that a stalled consumer never loses a pixel.

---
 rtl/out_line_sequencer_if.sv | 14 +
 rtl/out_line_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/out_line_sequencer_if.sv
// Output pixel stream of the line sequencer: valid/ready with end-of-line (tlast)
// and start-of-frame (tuser) tags.
interface out_line_sequencer_if #(
  parameter int unsigned dataWidth = 8
) ();
  logic [dataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/out_line_sequencer.sv
// Drains the pass-through (even rows) and interpolated (odd rows) line FIFOs in
// alternation into one tagged pixel stream; reads are paced by a 2-entry credit.
module out_line_sequencer #(
  parameter int unsigned dataWidth = 8,
  parameter int unsigned OUT_W     = 1280,
  parameter int unsigned OUT_H     = 960
) (
  input  logic                 aclk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [dataWidth-1:0] afifo0_out,
  input  logic                 afifo0_empty,
  input  logic                 afifo0_rd_rst_busy,
  output logic                 afifo0_rd_en,
  input  logic [dataWidth-1:0] afifo1_out,
  input  logic                 afifo1_empty,
  input  logic                 afifo1_rd_rst_busy,
  output logic                 afifo1_rd_en,
  output logic                 frame_done,
  out_line_sequencer_if.master m
);

  localparam int unsigned CW = $clog2(OUT_W);
  localparam int unsigned RW = $clog2(OUT_H);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  typedef struct packed {
    logic [dataWidth-1:0] data;
    logic                 last;
    logic                 user;
  } entry_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [RW-1:0] orow_q;
  logic [1:0]    occ_q;
  logic          infl_q, infl_src_q, infl_last_q, infl_user_q;
  entry_t        buf0_q, buf1_q;

  logic   busy, sel_odd, sel_empty, pop, credit_ok, rd_c, last_read;
  entry_t push_e;

  assign busy      = afifo0_rd_rst_busy | afifo1_rd_rst_busy;
  assign sel_odd   = row_q[0];
  assign sel_empty = sel_odd ? afifo0_empty : afifo1_empty;
  assign pop       = m.tvalid & m.tready;
  // Buffered plus in-flight pixels, net of this cycle's pop, must leave room.
  assign credit_ok = (3'(occ_q) + 3'(infl_q) - 3'(pop)) < 3'd2;
  assign last_read = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    rd_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !busy) state_d = ACTIVE;
      end
      ACTIVE: begin
        rd_c = !sel_empty && !busy && credit_ok;
        if (rd_c && last_read && !enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (occ_q == 2'd0 && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign afifo0_rd_en = rd_c & sel_odd;
  assign afifo1_rd_en = rd_c & ~sel_odd;

  // Issue-side position and the tags that travel with each read.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      infl_q      <= 1'b0;
      infl_src_q  <= 1'b0;
      infl_last_q <= 1'b0;
      infl_user_q <= 1'b0;
    end else begin
      infl_q <= rd_c;
      if (rd_c) begin
        infl_src_q  <= sel_odd;
        infl_last_q <= (col_q == COL_LAST);
        infl_user_q <= (col_q == '0) && (row_q == '0);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  assign push_e = {(infl_src_q ? afifo0_out : afifo1_out), infl_last_q, infl_user_q};

  // Two-entry output buffer; buf0 is always the head.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      buf0_q <= '0;
      buf1_q <= '0;
      orow_q <= '0;
    end else begin
      occ_q <= occ_q + 2'(infl_q) - 2'(pop);
      if (pop) buf0_q <= buf1_q;
      if (infl_q) begin
        if ((occ_q - 2'(pop)) == 2'd0) buf0_q <= push_e;
        else                           buf1_q <= push_e;
      end
      if (pop && buf0_q.last) orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + RW'(1);
    end
  end

  assign m.tvalid   = (occ_q != 2'd0);
  assign m.tdata    = buf0_q.data;
  assign m.tlast    = buf0_q.last;
  assign m.tuser    = buf0_q.user;
  assign frame_done = pop & buf0_q.last & (orow_q == ROW_LAST);

  always @(posedge aclk) begin
    if (rst_n) begin
      assert (!(infl_q && !pop && occ_q == 2'd2))
        else $error("output buffer overflow");
    end
  end

endmodule
